// File: rtl/bluetooth_uart_rx.sv
// UART receiver (8N1, or 8E1 when BT_UART_PARITY_EN is defined) feeding a byte FIFO.
// Presents the head byte and status flags as one 32-bit word for the read mux.
module bluetooth_uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RX,
  input  logic        POP,
  output logic [31:0] BLUETOOTH_OUT,
  output logic        RX_IRQ
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          PW           = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST    = 32'((CLKS_PER_BIT / 2) - 1);
  localparam logic [3:0]  DEPTH_C      = 4'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  logic          rx_meta_r, rx_sync_r;
  state_t        state_r, next_state_s;
  logic [31:0]   cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          cnt_clr_s, shift_en_s, par_en_s;
  logic          push_s, ferr_set_s, perr_set_s, par_err_s;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [3:0]    count_r;
  logic          ovr_r, ferr_r, perr_r;
  logic          pop_ok_s, full_s, push_ok_s, ovr_set_s;
  logic [7:0]    head_s;

`ifdef BT_UART_PARITY_EN
  logic par_err_r;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Latch the parity verdict so STOP can discard the byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_err_r <= 1'b0;
    end else if (par_en_s) begin
      par_err_r <= rx_sync_r ^ even_parity(shift_r);
    end else begin
      par_err_r <= par_err_r;
    end
  end
  assign par_err_s = par_err_r;
`else
  assign par_err_s = 1'b0;
`endif

  // Two-flop synchronizer; idle-high reset value avoids a spurious start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and per-sample strobes.
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b0;
    shift_en_s   = 1'b0;
    par_en_s     = 1'b0;
    push_s       = 1'b0;
    ferr_set_s   = 1'b0;
    perr_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (!rx_sync_r) next_state_s = ST_START;
        else            next_state_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_clr_s = 1'b1;
          if (rx_sync_r) next_state_s = ST_IDLE;
          else           next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s  = 1'b1;
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
`ifdef BT_UART_PARITY_EN
            next_state_s = ST_PARITY;
`else
            next_state_s = ST_STOP;
`endif
          end else begin
            next_state_s = ST_DATA;
          end
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
`ifdef BT_UART_PARITY_EN
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s    = 1'b1;
          par_en_s     = 1'b1;
          next_state_s = ST_STOP;
        end else begin
          next_state_s = ST_PARITY;
        end
`else
        next_state_s = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s    = 1'b1;
          next_state_s = ST_IDLE;
          push_s       = rx_sync_r & ~par_err_s;
          ferr_set_s   = ~rx_sync_r;
          perr_set_s   = par_err_s;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Baud counter, bit index and LSB-first shift register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r     <= 32'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      cnt_r <= cnt_clr_s ? 32'd0 : cnt_r + 32'd1;
      if (state_r == ST_IDLE) bit_idx_r <= 3'd0;
      else if (shift_en_s)    bit_idx_r <= bit_idx_r + 3'd1;
      else                    bit_idx_r <= bit_idx_r;
      if (shift_en_s) shift_r <= {rx_sync_r, shift_r[7:1]};
      else            shift_r <= shift_r;
    end
  end

  assign pop_ok_s  = POP && (count_r != 4'd0);
  assign full_s    = (count_r == DEPTH_C);
  assign push_ok_s = push_s && (!full_s || pop_ok_s);
  assign ovr_set_s = push_s && full_s && !pop_ok_s;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags: any POP clears them, a same-cycle set wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovr_r  <= 1'b0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      ovr_r  <= ovr_set_s  | (ovr_r  & ~POP);
      ferr_r <= ferr_set_s | (ferr_r & ~POP);
      perr_r <= perr_set_s | (perr_r & ~POP);
    end
  end

  // Status word assembled from registered state.
  always_comb begin
    if (count_r != 4'd0) head_s = mem_r[rd_ptr_r];
    else                 head_s = 8'h00;
    BLUETOOTH_OUT = {16'h0000, count_r, perr_r, ferr_r, ovr_r, (count_r != 4'd0), head_s};
  end

  assign RX_IRQ = (count_r != 4'd0);

endmodule

// File: tb/tb_bluetooth_uart_rx.sv
// Directed bench for bluetooth_uart_rx (CLKS_PER_BIT = 16) with a queue-based
// reference model compared every cycle, plus hand-computed literal checkpoints.
module tb_bluetooth_uart_rx;

  localparam int DEPTH = 8;
`ifdef BT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RX = 1'b1;
  logic        POP = 1'b0;
  logic [31:0] BLUETOOTH_OUT;
  logic        RX_IRQ;

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  logic [7:0] q[$];
  logic m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

  bluetooth_uart_rx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX(RX), .POP(POP),
    .BLUETOOTH_OUT(BLUETOOTH_OUT), .RX_IRQ(RX_IRQ)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    logic [7:0]  head;
    int n;
    n = q.size();
    head = (n != 0) ? q[0] : 8'h00;
    w = {16'h0000, 4'(n), m_perr, m_ferr, m_ovr, (n != 0), head};
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  // Effect of one clock edge on the abstract receiver state.
  task automatic model_apply(input logic pop, input logic ev_push, input logic ev_ferr,
                             input logic ev_perr, input logic [7:0] b);
    logic popping, full;
    popping = pop && (q.size() != 0);
    full    = (q.size() == DEPTH);
    if (pop) begin m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; end
    if (popping) void'(q.pop_front());
    if (ev_push) begin
      if (full && !popping) m_ovr = 1'b1;
      else q.push_back(b);
    end
    if (ev_ferr) m_ferr = 1'b1;
    if (ev_perr) m_perr = 1'b1;
  endtask

  // Drive one cycle of inputs; events describe what the receiver completes at the closing edge.
  task automatic cycle(input logic rx, input logic pop, input logic ev_push,
                       input logic ev_ferr, input logic ev_perr, input logic [7:0] b);
    RX = rx;
    POP = pop;
    @(posedge CLK);
    #1;
    if (!RST_N) model_reset();
    else model_apply(pop, ev_push, ev_ferr, ev_perr, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_pop();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    POP = 1'b0;
  endtask

  // The stop bit is judged mid-bit: 2 sync + 1 detect + 8 half-bit + 16*(NB-1) edges after the start edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                            input int pop_at);
    logic [10:0] bits;
    logic bad_par;
    int pc;
    pc = 16 * NB - 6;
    if (NB == 11) bits = {stop_bit, par_bit, d, 1'b0};
    else          bits = {1'b1, stop_bit, d, 1'b0};
    bad_par = (NB == 11) && (par_bit != ^d);
    for (int c = 0; c < 16 * NB; c++) begin
      if (c == pc)
        cycle(bits[c / 16], (c == pop_at), stop_bit && !bad_par, !stop_bit, bad_par, d);
      else
        cycle(bits[c / 16], (c == pop_at), 1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] exp_w, input logic exp_irq);
    n_cmp++;
    if (BLUETOOTH_OUT !== exp_w || RX_IRQ !== exp_irq) begin
      n_fail++;
      $display("FAIL %s: dut word=%08h irq=%b, expected word=%08h irq=%b",
               name, BLUETOOTH_OUT, RX_IRQ, exp_w, exp_irq);
    end
    n_cmp++;
    if (model_word() !== exp_w) begin
      n_fail++;
      $display("FAIL %s(model): model word=%08h, expected %08h", name, model_word(), exp_w);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      n_cmp++;
      if (BLUETOOTH_OUT !== model_word() || RX_IRQ !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL cycle_cmp @%0t: dut word=%08h irq=%b, expected word=%08h irq=%b",
                 $time, BLUETOOTH_OUT, RX_IRQ, model_word(), (q.size() != 0));
      end
    end
  end

  function automatic logic par_of(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) cycle(1'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_lit("reset_hold", 32'h00000000, 1'b0);
    RST_N = 1'b1;
    idle(200);
    check_lit("reset_idle", 32'h00000000, 1'b0);

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(40);
    check_lit("glitch", 32'h00000000, 1'b0);

    send_frame(8'hA5, 1'b1, par_of(8'hA5), -1);
    check_lit("single_a5", 32'h000011A5, 1'b1);
    do_pop();
    check_lit("pop_a5", 32'h00000000, 1'b0);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, par_of(8'(i)), -1);
    check_lit("overrun", 32'h00008301, 1'b1);
    do_pop();
    check_lit("overrun_pop", 32'h00007102, 1'b1);
    for (int i = 0; i < 8; i++) do_pop();
    check_lit("drain_empty_pop", 32'h00000000, 1'b0);

    send_frame(8'h3C, 1'b0, par_of(8'h3C), -1);
    idle(30);
    check_lit("frame_err", 32'h00000400, 1'b0);
    send_frame(8'h55, 1'b1, par_of(8'h55), -1);
    check_lit("good_after_ferr", 32'h00001555, 1'b1);
    send_frame(8'h66, 1'b1, par_of(8'h66), 16 * NB - 6);
    check_lit("push_pop_same", 32'h00001166, 1'b1);
    do_pop();
    check_lit("pop_66", 32'h00000000, 1'b0);

`ifdef BT_UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    check_lit("parity_bad", 32'h00000800, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    check_lit("parity_good", 32'h00001907, 1'b1);
`endif

    idle(4);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
